// File: rtl/uart_apb_ctrl.sv
// APB register block for the UART: divisor, CTRL/STATUS, FIFO strobes,
// TX start scheduling and a level interrupt.
module uart_apb_ctrl #(
    parameter int D_W     = 8,
    parameter int DIV_W   = 16,
    parameter int APB_AW  = 8,
    parameter int DIV_RST = 54
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [D_W-1:0]    PWDATA,
    output logic              PREADY,
    output logic [D_W-1:0]    PRDATA,
    output logic              PSLVERR,
    output logic [DIV_W-1:0]  divxr,
    output logic              tx_wr_en,
    output logic [D_W-1:0]    tx_wdata,
    input  logic              tx_full,
    input  logic              tx_empty,
    output logic              rx_rd_en,
    input  logic [D_W-1:0]    rx_rdata,
    input  logic              rx_full,
    input  logic              rx_empty,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              irq
);

    localparam logic [2*D_W-1:0] DIV_INIT = (2*D_W)'(DIV_RST);

    localparam logic [APB_AW-1:0] A_CTRL = APB_AW'(0);
    localparam logic [APB_AW-1:0] A_DLO  = APB_AW'(1);
    localparam logic [APB_AW-1:0] A_DHI  = APB_AW'(2);
    localparam logic [APB_AW-1:0] A_TXD  = APB_AW'(3);
    localparam logic [APB_AW-1:0] A_RXD  = APB_AW'(4);
    localparam logic [APB_AW-1:0] A_STAT = APB_AW'(5);

    typedef enum logic [1:0] {IDLE, ACT, RESP} state_t;

    state_t state, state_nx;

    logic [APB_AW-1:0] addr_q;
    logic              wr_q;
    logic [D_W-1:0]    wdata_q;
    logic [2:0]        ctrl_q;
    logic [D_W-1:0]    lo_q, hi_q;
    logic [D_W-1:0]    rdata_q;
    logic              err_q, pop_q, commit_q;
    logic              tx_busy;

    logic              go;
    logic              err_c, push_c, pop_c;
    logic              wr_ctrl, wr_lo, wr_hi;
    logic [D_W-1:0]    rdata_c;
    logic [2*D_W-1:0]  div_full;
    logic [DIV_W-1:0]  div_c;
    logic              start_c;

    assign div_full = {hi_q, lo_q};
    assign div_c    = div_full[DIV_W-1:0];

    // APB state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // APB next state; the access is committed only in a valid ACT cycle
    always_comb begin
        state_nx = state;
        go       = 1'b0;
        unique case (state)
            IDLE: if (PSEL && !PENABLE) state_nx = ACT;
            ACT: begin
                if (PSEL && PENABLE) begin
                    go       = 1'b1;
                    state_nx = RESP;
                end else begin
                    state_nx = IDLE;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Register decode for the latched access
    always_comb begin
        err_c   = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        wr_ctrl = 1'b0;
        wr_lo   = 1'b0;
        wr_hi   = 1'b0;
        rdata_c = '0;
        case (addr_q)
            A_CTRL: if (wr_q) wr_ctrl = 1'b1; else rdata_c = D_W'(ctrl_q);
            A_DLO:  if (wr_q) wr_lo = 1'b1;   else rdata_c = lo_q;
            A_DHI:  if (wr_q) wr_hi = 1'b1;   else rdata_c = hi_q;
            A_TXD:  if (!wr_q || tx_full) err_c = 1'b1; else push_c = 1'b1;
            A_RXD:  if (wr_q || rx_empty) err_c = 1'b1; else pop_c = 1'b1;
            A_STAT: begin
                if (wr_q) err_c = 1'b1;
                else rdata_c = D_W'({tx_busy, rx_full, rx_empty,
                                     tx_full, tx_empty});
            end
            default: err_c = 1'b1;
        endcase
    end

    // FIFO strobes fire in ACT only; a reset in that cycle suppresses them
    assign tx_wr_en = go & push_c & ~rst;
    assign rx_rd_en = go & pop_c & ~rst;
    assign tx_wdata = wdata_q;

    // Response is visible only while PREADY; popped data comes straight
    // from the FIFO output that settles the cycle after the pop
    assign PREADY  = (state == RESP);
    assign PRDATA  = PREADY ? (pop_q ? rx_rdata : rdata_q) : '0;
    assign PSLVERR = PREADY & err_q;

    // Access latch, register writes and divisor commit
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            ctrl_q   <= '0;
            lo_q     <= DIV_INIT[D_W-1:0];
            hi_q     <= DIV_INIT[2*D_W-1:D_W];
            divxr    <= DIV_W'(DIV_RST);
            rdata_q  <= '0;
            err_q    <= 1'b0;
            pop_q    <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            if (state == IDLE && PSEL && !PENABLE) begin
                addr_q  <= PADDR;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
            end
            if (go) begin
                rdata_q  <= rdata_c;
                err_q    <= err_c;
                pop_q    <= pop_c;
                commit_q <= wr_hi;
                if (wr_ctrl) ctrl_q <= wdata_q[2:0];
                if (wr_lo)   lo_q   <= wdata_q;
                if (wr_hi)   hi_q   <= wdata_q;
            end
            if (state == RESP && commit_q)
                divxr <= (div_c == '0) ? DIV_W'(1) : div_c;
        end
    end

    // A frame-done clear wins; the next start waits one cycle
    assign start_c = ctrl_q[0] & ~tx_empty & ~tx_busy & ~tx_start & ~tx_done;

    // TX start pulse and busy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            tx_start <= start_c;
            if (tx_done)      tx_busy <= 1'b0;
            else if (start_c) tx_busy <= 1'b1;
        end
    end

    // Level interrupt
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= (ctrl_q[1] & ~rx_empty) |
                        (ctrl_q[2] & tx_empty & ~tx_busy);
    end

endmodule
